// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared constants, next-PC select encoding and helpers for the
// program-counter sequencer and its return-address stack.
// Optional feature macro used by the consumers: PC_SEQ_RAS_EN.
package pc_seq_pkg;

    // Default configuration of the fetch-stage PC.
    localparam int unsigned PC_ADDR_W     = 5;
    localparam int unsigned PC_STEP       = 1;
    localparam int unsigned PC_RESET_ADDR = 0;
    localparam int unsigned PC_RAS_DEPTH  = 4;

    // Next-PC source, listed in decreasing priority.
    typedef enum logic [2:0] {
        SEL_HOLD   = 3'd0,
        SEL_RET    = 3'd1,
        SEL_CALL   = 3'd2,
        SEL_BRANCH = 3'd3,
        SEL_SEQ    = 3'd4
    } pc_sel_e;

    // Width needed to count 0..depth valid stack entries.
    function automatic int unsigned depth_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack. A push onto a full stack
// overwrites the oldest entry and sets a sticky overflow flag.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   push_i            push push_data_i (caller guarantees not with pop_i)
//   pop_i             pop the top entry (ignored when empty)
//   push_data_i       return address to push
//   top_o             combinational view of the current top entry
//   empty_o           combinational, no valid entries
//   depth_o           registered count of valid entries
//   overflow_o        registered sticky overflow flag
module pc_ras
    import pc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = PC_ADDR_W,
    parameter int unsigned DEPTH  = PC_RAS_DEPTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [ADDR_W-1:0]         push_data_i,
    output logic [ADDR_W-1:0]         top_o,
    output logic                      empty_o,
    output logic [depth_w(DEPTH)-1:0] depth_o,
    output logic                      overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned DW    = depth_w(DEPTH);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;      // next free slot
    logic [DW-1:0]     depth_q, depth_d;
    logic              overflow_q, overflow_d;
    logic              full_c;

    assign full_c  = (depth_q == DW'(DEPTH));
    assign empty_o = (depth_q == '0);
    // Top entry sits just below the write pointer (wraps modulo DEPTH).
    assign top_o   = mem_q[ptr_q - PTR_W'(1)];

    // Pointer, depth and overflow next-state.
    always_comb begin
        ptr_d      = ptr_q;
        depth_d    = depth_q;
        overflow_d = overflow_q;
        if (push_i) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (full_c) begin
                overflow_d = 1'b1;
            end else begin
                depth_d = depth_q + DW'(1);
            end
        end else if (pop_i && !empty_o) begin
            ptr_d   = ptr_q - PTR_W'(1);
            depth_d = depth_q - DW'(1);
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            depth_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            depth_q    <= depth_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[ptr_q] <= push_data_i;
        end
    end

    assign depth_o    = depth_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with stall, branch/jump load and,
// when PC_SEQ_RAS_EN is defined, a hardware return-address stack for
// call/return. Without PC_SEQ_RAS_EN, call acts as branch, ret is ignored and
// the RAS outputs are tied to zero.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   stall_i             hold PC (highest priority)
//   branch_en_i         load branch_target_i
//   branch_target_i     branch/jump/call destination
//   call_en_i           load branch_target_i, push return address
//   ret_en_i            load popped return address
//   pc_o                registered PC
//   pc_plus_step_o      combinational pc_o + STEP (mod 2^ADDR_W)
//   ras_depth_o         valid stack entries
//   ras_underflow_o     one-cycle pulse after a ret on an empty stack
//   ras_overflow_o      sticky: a call pushed onto a full stack
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W     = PC_ADDR_W,
    parameter int unsigned STEP       = PC_STEP,
    parameter int unsigned RESET_ADDR = PC_RESET_ADDR,
    parameter int unsigned RAS_DEPTH  = PC_RAS_DEPTH
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          stall_i,
    input  logic                          branch_en_i,
    input  logic [ADDR_W-1:0]             branch_target_i,
    input  logic                          call_en_i,
    input  logic                          ret_en_i,
    output logic [ADDR_W-1:0]             pc_o,
    output logic [ADDR_W-1:0]             pc_plus_step_o,
    output logic [depth_w(RAS_DEPTH)-1:0] ras_depth_o,
    output logic                          ras_underflow_o,
    output logic                          ras_overflow_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ras_top_c;
    logic              ras_empty_c;
    pc_sel_e           sel_c;

    // Truncating add gives the wrap-around at 2^ADDR_W.
    assign pc_plus_step_o = pc_q + ADDR_W'(STEP);

`ifdef PC_SEQ_RAS_EN
    logic ras_underflow_q;

    // Priority: stall > ret > call > branch > sequential.
    always_comb begin
        sel_c = SEL_SEQ;
        if (stall_i) begin
            sel_c = SEL_HOLD;
        end else if (ret_en_i) begin
            sel_c = SEL_RET;
        end else if (call_en_i) begin
            sel_c = SEL_CALL;
        end else if (branch_en_i) begin
            sel_c = SEL_BRANCH;
        end
    end

    pc_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (sel_c == SEL_CALL),
        .pop_i       (sel_c == SEL_RET),
        .push_data_i (pc_plus_step_o),
        .top_o       (ras_top_c),
        .empty_o     (ras_empty_c),
        .depth_o     (ras_depth_o),
        .overflow_o  (ras_overflow_o)
    );

    // Underflow pulses for exactly one cycle after a ret on an empty stack.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ras_underflow_q <= 1'b0;
        end else begin
            ras_underflow_q <= (sel_c == SEL_RET) && ras_empty_c;
        end
    end

    assign ras_underflow_o = ras_underflow_q;
`else
    logic unused_ret;

    // No stack: call is a plain branch, ret falls through to sequential.
    always_comb begin
        sel_c = SEL_SEQ;
        if (stall_i) begin
            sel_c = SEL_HOLD;
        end else if (call_en_i || branch_en_i) begin
            sel_c = SEL_BRANCH;
        end
    end

    assign unused_ret      = ret_en_i;
    assign ras_top_c       = '0;
    assign ras_empty_c     = 1'b1;
    assign ras_depth_o     = '0;
    assign ras_underflow_o = 1'b0;
    assign ras_overflow_o  = 1'b0;
`endif

    // Next-PC mux; a ret on an empty stack still advances sequentially.
    always_comb begin
        pc_d = pc_plus_step_o;
        case (sel_c)
            SEL_HOLD:   pc_d = pc_q;
            SEL_RET:    pc_d = ras_empty_c ? pc_plus_step_o : ras_top_c;
            SEL_CALL:   pc_d = branch_target_i;
            SEL_BRANCH: pc_d = branch_target_i;
            default:    pc_d = pc_plus_step_o;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= ADDR_W'(RESET_ADDR);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed stimulus against a queue-based behavioural model
// of the PC/return-stack rules, plus literal expectations for key points.
// Follows PC_SEQ_RAS_EN the same way the design does.
module tb_pc_sequencer;

    localparam int unsigned AW   = 5;
    localparam int unsigned STP  = 1;
    localparam int unsigned RADR = 0;
    localparam int unsigned RD   = 4;
    localparam int          MOD  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall, branch_en, call_en, ret_en;
    logic [AW-1:0] target;
    logic [AW-1:0] pc, pps;
    logic [2:0]    dep;
    logic          under, over;

    int vectors = 0;
    int errors  = 0;

    // Behavioural model state.
    int m_pc    = RADR;
    int m_stk[$];
    bit m_under = 1'b0;
    bit m_over  = 1'b0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .ADDR_W     (AW),
        .STEP       (STP),
        .RESET_ADDR (RADR),
        .RAS_DEPTH  (RD)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .stall_i         (stall),
        .branch_en_i     (branch_en),
        .branch_target_i (target),
        .call_en_i       (call_en),
        .ret_en_i        (ret_en),
        .pc_o            (pc),
        .pc_plus_step_o  (pps),
        .ras_depth_o     (dep),
        .ras_underflow_o (under),
        .ras_overflow_o  (over)
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: apply the next-PC rules on each rising edge.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_pc = RADR;
                m_stk.delete();
                m_under = 1'b0;
                m_over  = 1'b0;
            end else begin
                m_under = 1'b0;
                if (stall) begin
                    m_pc = m_pc;
`ifdef PC_SEQ_RAS_EN
                end else if (ret_en) begin
                    if (m_stk.size() > 0) begin
                        m_pc = m_stk.pop_back();
                    end else begin
                        m_pc = (m_pc + STP) % MOD;
                        m_under = 1'b1;
                    end
                end else if (call_en) begin
                    if (m_stk.size() == RD) begin
                        void'(m_stk.pop_front());
                        m_over = 1'b1;
                    end
                    m_stk.push_back((m_pc + STP) % MOD);
                    m_pc = int'(target);
`else
                end else if (call_en) begin
                    m_pc = int'(target);
`endif
                end else if (branch_en) begin
                    m_pc = int'(target);
                end else begin
                    m_pc = (m_pc + STP) % MOD;
                end
            end
        end
    end

    // Compare DUT against model every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("pc", int'(pc), m_pc);
            chk("pc_plus_step", int'(pps), (m_pc + STP) % MOD);
            chk("ras_depth", int'(dep), m_stk.size());
            chk("ras_underflow", int'(under), int'(m_under));
            chk("ras_overflow", int'(over), int'(m_over));
        end
    end

    task automatic cyc(input logic st, br, ca, re, input logic [AW-1:0] tgt);
        stall = st; branch_en = br; call_en = ca; ret_en = re; target = tgt;
        @(posedge clk);
        #1;
    endtask

    localparam bit RAS = `ifdef PC_SEQ_RAS_EN 1'b1 `else 1'b0 `endif ;

    initial begin
        rst = 1'b1;
        stall = 0; branch_en = 0; call_en = 0; ret_en = 0; target = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("lit_rst_pc", int'(pc), 0);
        chk("lit_rst_pps", int'(pps), 1);
        chk("lit_rst_depth", int'(dep), 0);
        rst = 1'b0;

        // Free-running increment with wrap.
        for (int i = 1; i <= 33; i++) begin
            cyc(0, 0, 0, 0, 0);
            if (i == 31) begin
                chk("lit_pc31", int'(pc), 31);
                chk("lit_pps_wrap", int'(pps), 0);
            end
            if (i == 32) chk("lit_pc_wrap0", int'(pc), 0);
        end
        chk("lit_pc_after33", int'(pc), 1);

        // Stall beats branch.
        cyc(0, 1, 0, 0, 7);
        chk("lit_branch7", int'(pc), 7);
        repeat (3) cyc(1, 1, 0, 0, 20);
        chk("lit_stall_hold", int'(pc), 7);
        cyc(0, 0, 0, 0, 0);
        chk("lit_after_stall", int'(pc), 8);

        // Call then return.
        cyc(0, 1, 0, 0, 3);
        cyc(0, 0, 1, 0, 12);
        chk("lit_call12", int'(pc), 12);
        chk("lit_call_depth", int'(dep), RAS ? 1 : 0);
        cyc(0, 0, 0, 0, 0);
        chk("lit_call_seq", int'(pc), 13);
        cyc(0, 0, 0, 1, 0);
        chk("lit_ret", int'(pc), RAS ? 4 : 14);
        chk("lit_ret_depth", int'(dep), 0);

        // Stalled ret on empty stack: no underflow.
        cyc(1, 0, 0, 1, 0);
        chk("lit_stall_ret_uf", int'(under), 0);

        // Five nested calls into a 4-deep stack, then five rets.
        cyc(0, 1, 0, 0, 1);
        for (int t = 10; t <= 14; t++) begin
            cyc(0, 0, 1, 0, AW'(t));
            if (t == 13) chk("lit_no_ovf_yet", int'(over), 0);
        end
        chk("lit_ovf", int'(over), RAS ? 1 : 0);
        chk("lit_full_depth", int'(dep), RAS ? 4 : 0);
        for (int r = 0; r < 4; r++) begin
            cyc(0, 0, 0, 1, 0);
            chk("lit_nested_ret", int'(pc), RAS ? 14 - r : 15 + r);
        end
        cyc(0, 0, 0, 1, 0);
        chk("lit_uf_pc", int'(pc), RAS ? 12 : 19);
        chk("lit_uf_pulse", int'(under), RAS ? 1 : 0);
        cyc(0, 0, 0, 0, 0);
        chk("lit_uf_clear", int'(under), 0);
        chk("lit_ovf_sticky", int'(over), RAS ? 1 : 0);

        // Simultaneous call and ret: ret wins.
        cyc(0, 1, 0, 0, 8);
        cyc(0, 0, 1, 0, 20);
        cyc(0, 0, 1, 1, 25);
        chk("lit_callret_pc", int'(pc), RAS ? 9 : 25);
        chk("lit_callret_depth", int'(dep), 0);

        // Asynchronous reset in the middle of a cycle.
        cyc(0, 0, 1, 0, 3);
        stall = 0; branch_en = 0; call_en = 0; ret_en = 0;
        #3;
        rst = 1'b1;
        #1;
        chk("lit_arst_pc", int'(pc), 0);
        chk("lit_arst_depth", int'(dep), 0);
        chk("lit_arst_ovf", int'(over), 0);
        chk("lit_arst_uf", int'(under), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0);
        chk("lit_post_rst", int'(pc), 1);

        // Call 6 from pc 2, then ret.
        cyc(0, 1, 0, 0, 2);
        cyc(0, 0, 1, 0, 6);
        chk("lit_call6", int'(pc), 6);
        cyc(0, 0, 0, 1, 0);
        chk("lit_ret_after6", int'(pc), RAS ? 3 : 7);
        chk("lit_ret6_depth", int'(dep), 0);
        cyc(0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the RISC core's fetch stage, the next generation of the fixed 5-bit PC incrementer. It holds the registered PC, advances it by a configurable word step with wrap-around, and supports stall, branch/jump load, and, optionally, a hardware return-address stack (RAS) for call/return. Its output drives the instruction-memory address; all control inputs come from decode/branch resolution.

## Interface
- ADDR_W, 5, PC width in bits (instruction memory is word-addressed)
- STEP, 1, increment per sequential fetch; 1 ≤ STEP < 2^ADDR_W
- RESET_ADDR, 0, PC value after reset
- RAS_DEPTH, 4, return-stack entries; power of two, ≥ 2 (used only with PC_SEQ_RAS_EN)

- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hold PC this cycle
- branch_en  in  1  load branch_target
- branch_target  in  ADDR_W  branch/jump/call destination
- call_en  in  1  call: load branch_target, push return address
- ret_en  in  1  return: load popped address
- pc  out  ADDR_W  current registered PC
- pc_plus_step  out  ADDR_W  combinational pc + STEP, mod 2^ADDR_W
- ras_depth  out  clog2(RAS_DEPTH)+1  valid stack entries
- ras_underflow  out  1  one-cycle pulse: ret on empty stack
- ras_overflow  out  1  sticky: call pushed onto full stack

## Operation
- Next-PC select priority, evaluated each rising edge: stall > ret_en > call_en > branch_en > sequential.
- stall: pc, stack, ras_depth unchanged; other controls ignored that cycle; no underflow pulse.
- ret_en, stack non-empty: pc ← top entry; pop; ras_depth −1.
- ret_en, stack empty: pc ← pc_plus_step; ras_underflow = 1 next cycle only; depth stays 0.
- call_en (no ret_en): pc ← branch_target; push pc_plus_step; depth +1 saturating at RAS_DEPTH.
- call on full stack: oldest entry overwritten (circular buffer), depth stays RAS_DEPTH, ras_overflow set and held until rst.
- branch_en alone: pc ← branch_target; stack untouched.
- Sequential: pc ← pc_plus_step.
- Arithmetic: all adds truncated to ADDR_W; pc = 2^ADDR_W − STEP wraps to 0 (ADDR_W=5, STEP=1: 31 → 0). branch_target used as-is, no alignment check.
- Simultaneous call_en and ret_en: ret wins, call ignored.

## Timing
- Reset (async assert, any time, including mid-call/ret): pc = RESET_ADDR, ras_depth = 0, ras_underflow = 0, ras_overflow = 0, stack contents don't-care. Deassertion synchronous to clk by the reset-synchroniser upstream.
- Controls sampled at rising edge; new pc visible after that edge (1-cycle latency).
- pc_plus_step is combinational from pc, 0-cycle latency.
- Stack push/pop and ras_depth update on the same edge as pc.
- ras_underflow asserted exactly the cycle after the offending edge.

## Configuration
- PC_SEQ_RAS_EN defined: full RAS behaviour as above.
- Not defined: no stack storage; call_en behaves as branch_en; ret_en ignored (sequential increment); ras_depth, ras_underflow, ras_overflow tied to 0. RAS_DEPTH unused.

## Structure
- Shared package pc_seq_pkg: default ADDR_W/STEP/RESET_ADDR constants, next-PC select enum (SEL_HOLD, SEL_RET, SEL_CALL, SEL_BRANCH, SEL_SEQ), depth-width function.
- One sub-module: pc_ras (circular return stack, push/pop/depth/overflow), instantiated only under PC_SEQ_RAS_EN.

## Test plan
- Reset then 33 idle cycles, ADDR_W=5, STEP=1 -> pc 0,1,…,31,0,1; pc_plus_step always pc+1 mod 32.
- pc=7, stall 3 cycles with branch_en, target 20 -> pc stays 7; after release, sequential 8.
- pc=3, call target 12; two cycles later ret -> pc 12,13,4; ras_depth 0→1→1→0.
- RAS_DEPTH=4, five nested calls from pc 1,10,11,12,13 (targets 10..14) then five rets -> first four rets return 14,13,12,11; ras_overflow high from 5th call; 5th ret underflows: pc increments, ras_underflow one-cycle pulse.
- call_en and ret_en together with depth 1, top=9 -> pc 9, depth 0; assert rst mid-sequence -> pc 0, depth 0, flags 0 immediately.
- Build without PC_SEQ_RAS_EN: call target 6 from pc 2 -> pc 6; ret -> pc 7; RAS outputs stay 0.
